// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions and the MAC scheduler state encoding.
package dlfloat_pkg;

    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 6;
    localparam int unsigned MANT_W   = 9;
    localparam int unsigned EXP_BIAS = 31;

    localparam logic [15:0] DLF_ZERO = 16'h0000;
    localparam logic [15:0] DLF_SAT  = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } sched_state_e;

endpackage

// File: rtl/dlfloat_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a job completes.
module dlfloat_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_done,
    input  logic       i_done_id,
    output logic       o_gnt_vld,
    output logic       o_gnt_id
);

    logic r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_done) begin
            r_ptr <= ~i_done_id;
        end
    end

    always_comb begin
        o_gnt_vld = |i_req;
        o_gnt_id  = 1'b0;
        if (i_req == 2'b11) begin
            o_gnt_id = r_ptr;
        end else if (i_req[1]) begin
            o_gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/dlfloat_mac_sched.sv
// Job-level scheduler sharing one dlfloat_mac between two requesters.
// Optional beat counter on res_cnt enabled by defining MAC_SCHED_CNT_EN.
module dlfloat_mac_sched
    import dlfloat_pkg::*;
#(
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_vld,
    output logic             r0_rdy,
    input  logic [15:0]      r0_a,
    input  logic [15:0]      r0_b,
    input  logic             r0_last,
    input  logic             r1_vld,
    output logic             r1_rdy,
    input  logic [15:0]      r1_a,
    input  logic [15:0]      r1_b,
    input  logic             r1_last,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic             mac_clr,
    input  logic [15:0]      mac_acc,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [15:0]      res_data,
    output logic             res_id,
    output logic [CNT_W-1:0] res_cnt
);

    localparam int unsigned DRN_W = (MAC_LAT == 0) ? 1 : $clog2(MAC_LAT + 1);

    sched_state_e     r_state, w_state_d;
    logic             r_gnt;
    logic [DRN_W-1:0] r_drain;
    logic [15:0]      r_res_data;
    logic             r_res_id;
    logic [CNT_W-1:0] r_res_cnt;
    logic [CNT_W-1:0] w_cnt;

    logic             w_sel_vld, w_sel_last;
    logic [15:0]      w_sel_a, w_sel_b;
    logic             w_beat, w_clr;
    logic             w_arb_vld, w_arb_id;

    assign w_sel_vld  = r_gnt ? r1_vld  : r0_vld;
    assign w_sel_last = r_gnt ? r1_last : r0_last;
    assign w_sel_a    = r_gnt ? r1_a    : r0_a;
    assign w_sel_b    = r_gnt ? r1_b    : r0_b;

    dlfloat_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({r1_vld, r0_vld}),
        .i_done    (w_clr),
        .i_done_id (r_gnt),
        .o_gnt_vld (w_arb_vld),
        .o_gnt_id  (w_arb_id)
    );

    always_comb begin
        w_state_d = r_state;
        r0_rdy    = 1'b0;
        r1_rdy    = 1'b0;
        mac_a     = DLF_ZERO;
        mac_b     = DLF_ZERO;
        w_beat    = 1'b0;
        w_clr     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_arb_vld) begin
                    w_state_d = StStream;
                end
            end
            StStream: begin
                r0_rdy = ~r_gnt;
                r1_rdy = r_gnt;
                // Operands reach the MAC only on accepted beats; gaps add a zero product.
                if (w_sel_vld) begin
                    w_beat = 1'b1;
                    mac_a  = w_sel_a;
                    mac_b  = w_sel_b;
                    if (w_sel_last) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (r_drain == '0) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (res_rdy) begin
                    w_clr     = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_gnt      <= 1'b0;
            r_drain    <= '0;
            r_res_data <= DLF_ZERO;
            r_res_id   <= 1'b0;
            r_res_cnt  <= '0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                StIdle: begin
                    if (w_arb_vld) begin
                        r_gnt <= w_arb_id;
                    end
                end
                StStream: begin
                    if (w_beat && w_sel_last) begin
                        r_drain <= DRN_W'(MAC_LAT);
                    end
                end
                StDrain: begin
                    if (r_drain == '0) begin
                        r_res_data <= mac_acc;
                        r_res_id   <= r_gnt;
                        r_res_cnt  <= w_cnt;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MAC_SCHED_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == StIdle) begin
            r_cnt <= '0;
        end else if (w_beat && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_cnt = r_cnt;
`else
    assign w_cnt = '0;
`endif

    // Clear is held through reset so the datapath starts each job from zero.
    assign mac_clr  = w_clr | rst;
    assign res_vld  = (r_state == StDone);
    assign res_data = r_res_data;
    assign res_id   = r_res_id;
    assign res_cnt  = r_res_cnt;

endmodule

// File: tb/tb_dlfloat_mac_sched.sv
// Bench for dlfloat_mac_sched: real-valued MAC model, result scoreboard, directed jobs.
module tb_dlfloat_mac_sched;

    localparam int CNT_W = 8;
`ifdef MAC_SCHED_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             r0_vld = 1'b0, r0_rdy, r0_last = 1'b0;
    logic [15:0]      r0_a = 16'h0, r0_b = 16'h0;
    logic             r1_vld = 1'b0, r1_rdy, r1_last = 1'b0;
    logic [15:0]      r1_a = 16'h0, r1_b = 16'h0;
    logic [15:0]      mac_a, mac_b, mac_acc;
    logic             mac_clr;
    logic             res_vld, res_id;
    logic             res_rdy = 1'b1;
    logic [15:0]      res_data;
    logic [CNT_W-1:0] res_cnt;

    always #5 clk = ~clk;

    dlfloat_mac_sched #(.MAC_LAT(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .r0_vld(r0_vld), .r0_rdy(r0_rdy), .r0_a(r0_a), .r0_b(r0_b), .r0_last(r0_last),
        .r1_vld(r1_vld), .r1_rdy(r1_rdy), .r1_a(r1_a), .r1_b(r1_b), .r1_last(r1_last),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data), .res_id(res_id),
        .res_cnt(res_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic real dec(input logic [15:0] x);
        real v;
        int  e;
        if (x[14:0] == 15'h0) return 0.0;
        v = 1.0 + real'(x[8:0]) / 512.0;
        e = int'(x[14:9]) - 31;
        for (int i = 0; i < e; i++) v = v * 2.0;
        for (int i = 0; i < -e; i++) v = v / 2.0;
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] enc(input real val);
        real         v;
        int          e;
        logic        s;
        logic [5:0]  ef;
        logic [8:0]  mf;
        if (val == 0.0) return 16'h0000;
        s = (val < 0.0);
        v = s ? -val : val;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        ef = 6'(e + 31);
        mf = 9'(int'((v - 1.0) * 512.0));
        return {s, ef, mf};
    endfunction

    // Datapath model: product register, then accumulator register; clear wins.
    real m_prod = 0.0, m_acc = 0.0;
    bit  m_prod_sat = 1'b0, m_acc_sat = 1'b0;

    always @(posedge clk) begin
        if (mac_clr) begin
            m_acc     <= 0.0;
            m_acc_sat <= 1'b0;
        end else begin
            m_acc     <= m_acc + m_prod;
            m_acc_sat <= m_acc_sat | m_prod_sat;
        end
        m_prod     <= dec(mac_a) * dec(mac_b);
        m_prod_sat <= (mac_a == 16'hFFFF) || (mac_b == 16'hFFFF);
    end

    assign mac_acc = m_acc_sat ? 16'hFFFF : enc(m_acc);

    typedef struct {
        logic [15:0] data;
        logic        id;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ja[2][512];
    logic [15:0] jb[2][512];

    task automatic push_exp(input int id, input int n);
        exp_t e;
        real  sum = 0.0;
        bit   sat = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (ja[id][i] == 16'hFFFF || jb[id][i] == 16'hFFFF) sat = 1'b1;
            sum = sum + dec(ja[id][i]) * dec(jb[id][i]);
        end
        e.data = sat ? 16'hFFFF : enc(sum);
        e.id   = id[0];
        e.cnt  = CntEn ? ((n > 255) ? 8'd255 : 8'(n)) : 8'd0;
        exp_q.push_back(e);
    endtask

    // Per-cycle scoreboard and protocol checks.
    int          n_res = 0;
    int          clr_pulses = 0;
    logic [15:0] last_data = 16'h0;
    logic        last_id = 1'b0;
    logic [7:0]  last_cnt = 8'h0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic        prev_id = 1'b0;
    exp_t        cur_e;
    logic [15:0] ea, eb;

    always @(negedge clk) begin
        if (rst) begin
            chk(mac_clr == 1'b1, "clr_in_reset", {31'b0, mac_clr}, 32'h1);
            prev_hold = 1'b0;
        end else begin
            ea = 16'h0;
            eb = 16'h0;
            if (r0_vld && r0_rdy) begin ea = r0_a; eb = r0_b; end
            if (r1_vld && r1_rdy) begin ea = r1_a; eb = r1_b; end
            chk(mac_a == ea && mac_b == eb, "mac_operands", {mac_a, mac_b}, {ea, eb});
            chk(mac_clr == (res_vld && res_rdy), "mac_clr", {31'b0, mac_clr},
                {31'b0, res_vld && res_rdy});
            if (mac_clr) clr_pulses++;
            if (r0_rdy && r1_rdy) chk(1'b0, "both_rdy", 32'h3, 32'h0);
            if (res_vld) chk(!r0_rdy && !r1_rdy, "rdy_in_done", {30'b0, r1_rdy, r0_rdy}, 32'h0);
            if (prev_hold) begin
                chk(res_vld && res_data == prev_data && res_id == prev_id, "res_stable",
                    {15'b0, res_vld, res_data}, {15'b0, 1'b1, prev_data});
            end
            if (res_vld && res_rdy) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_result", {15'b0, res_id, res_data}, 32'h0);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk(res_data == cur_e.data, "res_data", {16'b0, res_data}, {16'b0, cur_e.data});
                    chk(res_id == cur_e.id, "res_id", {31'b0, res_id}, {31'b0, cur_e.id});
                    chk(res_cnt == cur_e.cnt, "res_cnt", {24'b0, res_cnt}, {24'b0, cur_e.cnt});
                end
                n_res++;
                last_data = res_data;
                last_id   = res_id;
                last_cnt  = res_cnt;
            end
            prev_hold = res_vld && !res_rdy;
            prev_data = res_data;
            prev_id   = res_id;
        end
    end

    task automatic set_req(input int id, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic l);
        if (id == 0) begin r0_vld = v; r0_a = a; r0_b = b; r0_last = l; end
        else begin r1_vld = v; r1_a = a; r1_b = b; r1_last = l; end
    endtask

    function automatic logic cur_rdy(input int id);
        return (id == 0) ? r0_rdy : r1_rdy;
    endfunction

    task automatic drive_job(input int id, input int n, input int gap_after, input int gap_len);
        int t;
        for (int i = 0; i < n; i++) begin
            set_req(id, 1'b1, ja[id][i], jb[id][i], i == n - 1);
            t = 0;
            @(negedge clk);
            while (!cur_rdy(id) && t < 3000) begin @(negedge clk); t++; end
            if (t >= 3000) chk(1'b0, "req_timeout", 32'(id), 32'(i));
            @(posedge clk); #1;
            if (i == gap_after) begin
                set_req(id, 1'b0, 16'h0, 16'h0, 1'b0);
                repeat (gap_len) begin @(posedge clk); #1; end
            end
        end
        set_req(id, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic wait_res(input int target);
        int t = 0;
        while (n_res < target && t < 5000) begin @(negedge clk); t++; end
        chk(n_res >= target, "result_timeout", 32'(n_res), 32'(target));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({r0_rdy, r1_rdy, res_vld, res_id} == 4'b0, {tag, "_ctl"},
            {28'b0, r0_rdy, r1_rdy, res_vld, res_id}, 32'h0);
        chk(mac_a == 16'h0 && mac_b == 16'h0, {tag, "_mac_ops"}, {mac_a, mac_b}, 32'h0);
        chk(mac_clr == 1'b1, {tag, "_clr"}, {31'b0, mac_clr}, 32'h1);
        chk(res_data == 16'h0 && res_cnt == '0, {tag, "_res"}, {8'b0, res_cnt, res_data}, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int t_hold;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;

        // Single r0 job: 1*2 + 1*1 = 3.0
        ja[0][0] = 16'h3E00; jb[0][0] = 16'h4000;
        ja[0][1] = 16'h3E00; jb[0][1] = 16'h3E00;
        push_exp(0, 2);
        drive_job(0, 2, -1, 0);
        wait_res(1);
        chk(last_data == 16'h4100, "t1_data", {16'b0, last_data}, 32'h4100);
        chk(last_id == 1'b0, "t1_id", {31'b0, last_id}, 32'h0);
        chk(last_cnt == (CntEn ? 8'd2 : 8'd0), "t1_cnt", {24'b0, last_cnt}, CntEn ? 32'd2 : 32'd0);
        chk(clr_pulses == 1, "t1_clr_pulses", 32'(clr_pulses), 32'h1);

        // Simultaneous pair after reset: r0 first, then r1 (4+1 = 5.0)
        pulse_reset();
        ja[0][0] = 16'h3E00; jb[0][0] = 16'h4000;
        ja[1][0] = 16'h4000; jb[1][0] = 16'h4000;
        ja[1][1] = 16'h3E00; jb[1][1] = 16'h3E00;
        push_exp(0, 1);
        push_exp(1, 2);
        fork
            drive_job(0, 1, -1, 0);
            drive_job(1, 2, -1, 0);
        join
        wait_res(3);
        chk(last_id == 1'b1 && last_data == 16'h4280, "pairA_second", {15'b0, last_id, last_data},
            {15'b0, 1'b1, 16'h4280});

        // Same vectors as the first job with a 3-cycle gap: result unchanged
        ja[0][0] = 16'h3E00; jb[0][0] = 16'h4000;
        ja[0][1] = 16'h3E00; jb[0][1] = 16'h3E00;
        push_exp(0, 2);
        drive_job(0, 2, 0, 3);
        wait_res(4);
        chk(last_data == 16'h4100, "gap_data", {16'b0, last_data}, 32'h4100);

        // Pair B: r0 served last, so r1 wins; result held 5 cycles with res_rdy low
        ja[0][0] = 16'hFFFF; jb[0][0] = 16'h3E00;
        ja[0][1] = 16'h3E00; jb[0][1] = 16'h3E00;
        ja[1][0] = 16'h4000; jb[1][0] = 16'h3E00;
        push_exp(1, 1);
        push_exp(0, 2);
        res_rdy = 1'b0;
        fork
            drive_job(0, 2, -1, 0);
            drive_job(1, 1, -1, 0);
            begin : hold_blk
                t_hold = 0;
                while (!res_vld && t_hold < 3000) begin @(negedge clk); t_hold++; end
                chk(res_vld, "hold_reach_done", {31'b0, res_vld}, 32'h1);
                repeat (5) @(negedge clk);
                chk(res_vld && res_id == 1'b1 && res_data == 16'h4000, "hold_result",
                    {15'b0, res_id, res_data}, {15'b0, 1'b1, 16'h4000});
                chk(r0_vld && !r0_rdy && !r1_rdy, "hold_r0_blocked",
                    {29'b0, r0_vld, r0_rdy, r1_rdy}, 32'h4);
                @(posedge clk); #1 res_rdy = 1'b1;
            end
        join
        wait_res(6);
        chk(last_id == 1'b0 && last_data == 16'hFFFF, "sat_result", {15'b0, last_id, last_data},
            {16'h0, 16'hFFFF});

        // 300-beat job: only the first product is nonzero
        ja[0][0] = 16'h3E00; jb[0][0] = 16'h3E00;
        for (int i = 1; i < 300; i++) begin ja[0][i] = 16'h3E00; jb[0][i] = 16'h0000; end
        push_exp(0, 300);
        drive_job(0, 300, -1, 0);
        wait_res(7);
        chk(last_data == 16'h3E00, "long_data", {16'b0, last_data}, 32'h3E00);
        chk(last_cnt == (CntEn ? 8'd255 : 8'd0), "long_cnt", {24'b0, last_cnt},
            CntEn ? 32'd255 : 32'd0);

        // Reset in STREAM after one beat aborts the job
        set_req(0, 1'b1, 16'h4000, 16'h3E00, 1'b0);
        t_hold = 0;
        @(negedge clk);
        while (!r0_rdy && t_hold < 100) begin @(negedge clk); t_hold++; end
        chk(r0_rdy, "abort_grant", {31'b0, r0_rdy}, 32'h1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'h3E00, 16'h3E00, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_outs("abort");
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        ja[1][0] = 16'h4000; jb[1][0] = 16'h3E00;
        push_exp(1, 1);
        drive_job(1, 1, -1, 0);
        wait_res(8);
        chk(last_data == 16'h4000 && last_id == 1'b1, "post_abort", {15'b0, last_id, last_data},
            {15'b0, 1'b1, 16'h4000});
        chk(exp_q.size() == 0, "leftover_expect", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
